reg_scoreboard: RTL
===================

# reg_scoreboard

Register-hazard scoreboard sitting between instruction decode and issue in the RISC-V pipeline. It consumes the per-instruction register indices produced by the decode-stage register extractor (rd, rs1, rs2, rs3) and tracks which architectural registers have an outstanding write. It stalls issue on RAW and WAW hazards until the producing operation completes, either after a fixed latency or on an explicit writeback. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- ADDR_BITS, 5, register index width
- NREG, 32, number of architectural registers (x0 hard-wired zero)
- LAT_BITS, 3, width of the fixed-latency field
- CNT_BITS, 32, width of the stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous reset, active low
- id_valid  in  1  decode presents an instruction
- id_rd  in  ADDR_BITS  destination register
- id_rs1 / id_rs2 / id_rs3  in  ADDR_BITS  source registers
- id_rs_used  in  3  bit0=rs1, bit1=rs2, bit2=rs3 actually read
- id_rd_we  in  1  instruction writes id_rd
- id_lat  in  LAT_BITS  completion latency in cycles; 0 = variable latency, released by writeback
- id_ready  out  1  issue permitted; fire = id_valid & id_ready
- flush  in  1  pipeline flush; suppresses fire this cycle
- wb_valid  in  1  variable-latency writeback completes
- wb_rd  in  ADDR_BITS  register released by writeback
- busy_vec  out  NREG  registered busy bits, bit r = register r pending
- stall_cycles  out  CNT_BITS  count of cycles with id_valid & !id_ready & !flush

## Operation
- Per-register state: busy[r] (1 bit), cnt[r] (LAT_BITS). Entry r is "fixed" if busy with cnt!=0, and "variable" if busy with cnt==0.
- Register 0 is never busy. Reads of x0 never stall. Writes to x0 never mark busy.
- An entry r is releasing this cycle if:
  - it is fixed with cnt[r]==1, or
  - it is variable and wb_valid & wb_rd==r.
- Effective busy: eb[r] = busy[r] & !releasing[r]. This gives same-cycle release-to-issue bypass.
- Hazards:
  - RAW: for each i, id_rs_used[i] & eb[rs_i].
  - WAW: id_rd_we & id_rd!=0 & eb[id_rd].
- id_ready = !flush & !RAW & !WAW. It is independent of id_valid.
- On fire with id_rd_we & id_rd!=0: busy[id_rd]<=1, cnt[id_rd]<=id_lat.
- Each cycle, every fixed entry not being newly set decrements cnt. When cnt goes 1→0, busy clears.
- A variable entry clears busy on a matching wb_valid.
- A wb_valid targeting a non-busy or fixed entry, or x0, is ignored.
- Simultaneous release and fire-set on the same register: the set wins, with busy=1 and cnt=id_lat.
- stall_cycles increments when id_valid & !id_ready & !flush, and wraps at 2^CNT_BITS.
- flush does not clear outstanding entries. Older in-flight producers still complete.

## Timing
- Reset (asynchronous, rst_n low): all busy=0, cnt=0, stall_cycles=0, busy_vec=0. During reset id_ready=!flush.
- Deassertion of rst_n is synchronized externally. The first edge after release updates normally.
- id_ready is combinational from registered state plus id_*, wb_*, and flush. It has no registered latency.
- Fixed latency L≥1: a consumer of rd issued in cycle t can fire in cycle t+L at the earliest. It stalls in cycles t+1 through t+L-1.
- Variable latency: a consumer fires in the same cycle as the matching wb_valid.
- busy_vec reflects state after the last edge and does not include same-cycle release.
- Counter width/decrement saturates at 0. No underflow is possible by construction.

## Test plan
- Reset mid-operation: set busy[5] with lat=4, assert rst_n=0 for 1 cycle. Required: busy_vec=0, stall_cycles=0, and an instruction reading x5 has id_ready=1 immediately.
- Fixed-latency RAW: fire rd=3, lat=3 at t0, then present rs1=3 used. Required: id_ready=0 at t0+1 and t0+2, id_ready=1 at t0+3, and stall_cycles=2.
- Variable-latency RAW/WAW: fire rd=7, lat=0. A consumer with rs2=7, and a separate rd=7 writer, stall indefinitely. Required: wb_valid=1, wb_rd=7 makes id_ready=1 in that same cycle, and busy_vec[7]=0 next cycle unless the writer fired.
- Release-and-set collision: fire rd=9, lat=1, then next cycle fire rd=9, lat=2. Required: the second fires without stall, and busy[9] stays 1 for 2 more cycles.
- x0 and unused sources: fire rd=0 lat=4, then read rs1=0. Required: no stall. With busy[4] set, a source rs3=4 with id_rs_used[2]=0 gives id_ready=1.
- Flush and spurious writeback: flush=1 with a ready instruction gives id_ready=0, no state change, and no stall count. A wb_valid to a fixed entry (rd=6, lat=5) leaves it busy for its full latency.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-hazard scoreboard that stalls issue on RAW/WAW until producers complete.
module reg_scoreboard #(
    parameter int ADDR_BITS = 5,
    parameter int NREG      = 32,
    parameter int LAT_BITS  = 3,
    parameter int CNT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [ADDR_BITS-1:0] id_rd,
    input  logic [ADDR_BITS-1:0] id_rs1,
    input  logic [ADDR_BITS-1:0] id_rs2,
    input  logic [ADDR_BITS-1:0] id_rs3,
    input  logic [2:0]           id_rs_used,
    input  logic                 id_rd_we,
    input  logic [LAT_BITS-1:0]  id_lat,
    output logic                 id_ready,
    input  logic                 flush,
    input  logic                 wb_valid,
    input  logic [ADDR_BITS-1:0] wb_rd,
    output logic [NREG-1:0]      busy_vec,
    output logic [CNT_BITS-1:0]  stall_cycles
);
    logic [NREG-1:0]     busy_q, busy_d, eb;
    logic [LAT_BITS-1:0] cnt_q [NREG];
    logic [LAT_BITS-1:0] cnt_d [NREG];
    logic [CNT_BITS-1:0] stall_q, stall_d;
    logic                raw, waw, set;

    // Effective busy: pending entries minus those releasing this cycle, so a consumer issues on the release cycle
    always_comb begin
        eb = '0;
        for (int r = 1; r < NREG; r++) begin
            eb[r] = busy_q[r] & ~((cnt_q[r] == LAT_BITS'(1)) |
                                  ((cnt_q[r] == '0) & wb_valid & (wb_rd == ADDR_BITS'(r))));
        end
    end

    // Hazard detection and issue permission; x0 never appears busy in eb
    always_comb begin
        raw      = (id_rs_used[0] & eb[id_rs1]) | (id_rs_used[1] & eb[id_rs2]) | (id_rs_used[2] & eb[id_rs3]);
        waw      = id_rd_we & (id_rd != '0) & eb[id_rd];
        id_ready = ~flush & ~raw & ~waw;
        set      = id_valid & id_ready & id_rd_we & (id_rd != '0);
    end

    // Next state: a new set wins over release; fixed entries count down, variable entries wait for writeback
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        for (int r = 0; r < NREG; r++) begin
            if (set && id_rd == ADDR_BITS'(r)) begin
                busy_d[r] = 1'b1;
                cnt_d[r]  = id_lat;
            end else if (busy_q[r] && cnt_q[r] != '0) begin
                cnt_d[r]  = cnt_q[r] - LAT_BITS'(1);
                busy_d[r] = cnt_q[r] != LAT_BITS'(1);
            end else if (busy_q[r] && wb_valid && wb_rd == ADDR_BITS'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
        cnt_d[0]  = '0;
        stall_d   = stall_q + CNT_BITS'(id_valid & ~id_ready & ~flush);
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            stall_q <= '0;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_vec     = busy_q;
    assign stall_cycles = stall_q;
endmodule
